// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: turns controller fetch requests into a handshaked memory read,
// latches the word into IR and keeps a one-entry PC+1 prefetch buffer.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 13,
  parameter bit          PF_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              ReadFlag,
  input  logic              instruction,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        Opcode,
  output logic [2:0]        rd,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [6:0]        imm,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              pf_hit
);

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StPrefetch} state_e;

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic [15:0]       pf_data_q, pf_data_d;
  logic              pf_hit_q, pf_hit_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              start_q;
  logic              start, ack;
  logic [ADDR_W-1:0] req_addr;

  assign start    = ReadFlag & instruction & ~start_q;
  // Acks outside an active request (e.g. a read aborted by reset) are ignored.
  assign ack      = mem_ack & mem_req_q;
  assign req_addr = start ? PC : pend_addr_q;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fetch_addr_d = fetch_addr_q;
    pf_valid_d   = pf_valid_q;
    pf_addr_d    = pf_addr_q;
    pf_data_d    = pf_data_q;
    pf_hit_d     = 1'b0;
    pending_d    = pending_q;
    pend_addr_d  = pend_addr_q;
    // Any start not consumed directly in IDLE is remembered and served later.
    if (start) begin
      pending_d   = 1'b1;
      pend_addr_d = PC;
    end
    unique case (state_q)
      StIdle: begin
        if (start || pending_q) begin
          pending_d    = 1'b0;
          fetch_addr_d = req_addr;
          if (PF_ENABLE && pf_valid_q && (pf_addr_q == req_addr)) begin
            ir_d       = pf_data_q;
            ir_valid_d = 1'b1;
            pf_hit_d   = 1'b1;
            pf_valid_d = 1'b0;
            state_d    = StHold;
          end else begin
            ir_valid_d = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = req_addr;
            state_d    = StFetch;
          end
        end
      end
      StFetch: begin
        if (ack) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (PF_ENABLE && !pf_valid_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_addr_q + AddrOne;
          state_d    = StPrefetch;
        end else begin
          state_d = StIdle;
        end
      end
      StPrefetch: begin
        if (start) ir_valid_d = 1'b0;
        if (ack) begin
          if (!pending_q) begin
            pf_data_d  = mem_rdata;
            pf_addr_d  = mem_addr_q;
            pf_valid_d = 1'b1;
            mem_req_d  = 1'b0;
            state_d    = StIdle;
          end else begin
            if (!start) pending_d = 1'b0;
            fetch_addr_d = pend_addr_q;
            if (pend_addr_q == mem_addr_q) begin
              ir_d       = mem_rdata;
              ir_valid_d = 1'b1;
              pf_hit_d   = 1'b1;
              mem_req_d  = 1'b0;
              state_d    = StHold;
            end else begin
              // Wrong word in flight: drop it and relaunch back-to-back.
              ir_valid_d = 1'b0;
              mem_addr_d = pend_addr_q;
              state_d    = StFetch;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fetch_addr_q <= '0;
      pf_valid_q   <= 1'b0;
      pf_addr_q    <= '0;
      pf_data_q    <= '0;
      pf_hit_q     <= 1'b0;
      pending_q    <= 1'b0;
      pend_addr_q  <= '0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fetch_addr_q <= fetch_addr_d;
      pf_valid_q   <= pf_valid_d;
      pf_addr_q    <= pf_addr_d;
      pf_data_q    <= pf_data_d;
      pf_hit_q     <= pf_hit_d;
      pending_q    <= pending_d;
      pend_addr_q  <= pend_addr_d;
      start_q      <= ReadFlag & instruction;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign Opcode     = ir_q[15:13];
  assign rd         = ir_q[12:10];
  assign rs1        = ir_q[9:7];
  assign rs2        = ir_q[6:4];
  assign imm        = ir_q[6:0];
  assign ir_valid   = ir_valid_q;
  assign pf_hit     = pf_hit_q;
  assign fetch_busy = (state_q == StFetch) | (state_q == StPrefetch) | pending_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected IR words, a monitor
// pops them whenever the DUT presents a new instruction.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] PC;
  logic        ReadFlag, instruction;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [2:0]  Opcode, rd, rs1, rs2;
  logic [6:0]  imm;
  logic        ir_valid, fetch_busy, pf_hit;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PC         (PC),
    .ReadFlag   (ReadFlag),
    .instruction(instruction),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .Opcode     (Opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .pf_hit     (pf_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] word;
    logic        hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_cnt[8192];
  int   mem_wait = 3;
  logic stray = 1'b0;

  function automatic logic [15:0] mem_word(input logic [12:0] a);
    case (a)
      13'd0:   return 16'h2A85;
      13'd1:   return 16'h4C3B;
      13'd2:   return 16'h7F12;
      13'd5:   return 16'hA5A5;
      13'd6:   return 16'h1357;
      default: return 16'hD000 | {3'b000, a};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: acks mem_wait cycles after a request appears.
  int cnt = 0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (stray) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hFFFF;
    end else if (reset || !mem_req) begin
      cnt = 0;
    end else if (cnt == mem_wait) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
      ack_cnt[mem_addr]++;
      cnt = 0;
    end else begin
      cnt++;
    end
  end

  // Monitor: a new instruction is a pf_hit pulse or a rising ir_valid.
  logic ir_prev = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (pf_hit || (ir_valid && !ir_prev)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ir", {16'h0, Opcode, rd, rs1, imm}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("opcode", 32'(Opcode), 32'(e.word[15:13]));
        chk("rd",     32'(rd),     32'(e.word[12:10]));
        chk("rs1",    32'(rs1),    32'(e.word[9:7]));
        chk("rs2",    32'(rs2),    32'(e.word[6:4]));
        chk("imm",    32'(imm),    32'(e.word[6:0]));
        chk("hit",    32'(pf_hit), 32'(e.hit));
      end
    end
    ir_prev = ir_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [12:0] pc);
    PC          = pc;
    ReadFlag    = 1'b1;
    instruction = 1'b1;
    tick();
    ReadFlag    = 1'b0;
    instruction = 1'b0;
  endtask

  task automatic wait_ir();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ir_valid && n < 50);
    chk("wait_ir_valid", 32'(ir_valid), 32'd1);
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 2 && n < 60) begin
      tick();
      n++;
      if (!fetch_busy && !mem_req) q++;
      else q = 0;
    end
    chk("wait_quiet", 32'(q >= 2), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c2;
    int gap;
    int n;
    reset = 1'b1; ReadFlag = 1'b0; instruction = 1'b0; PC = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_opcode", 32'(Opcode), 0);
    chk("rst_imm", 32'(imm), 0);
    chk("rst_busy", 32'(fetch_busy), 0);
    reset = 1'b0;

    // Miss at PC=0, ReadFlag held high throughout.
    PC = 13'd0; ReadFlag = 1'b1; instruction = 1'b1;
    exp_q.push_back('{16'h2A85, 1'b0});
    tick();
    chk("s1_mem_req", 32'(mem_req), 1);
    chk("s1_mem_addr", 32'(mem_addr), 0);
    chk("s1_ir_valid", 32'(ir_valid), 0);
    wait_ir();
    chk("s1_opcode", 32'(Opcode), 1);
    chk("s1_rd", 32'(rd), 2);
    chk("s1_rs1", 32'(rs1), 5);
    chk("s1_rs2", 32'(rs2), 0);
    chk("s1_imm", 32'(imm), 5);
    tick();
    chk("s1_pf_req", 32'(mem_req), 1);
    chk("s1_pf_addr", 32'(mem_addr), 1);
    wait_quiet();
    chk("s1_one_fetch", 32'(ack_cnt[0]), 1);
    ReadFlag = 1'b0; instruction = 1'b0;
    tick();

    // Hit on PC=1.
    exp_q.push_back('{16'h4C3B, 1'b1});
    pulse_start(13'd1);
    chk("s2_pf_hit", 32'(pf_hit), 1);
    chk("s2_ir_valid", 32'(ir_valid), 1);
    chk("s2_no_req", 32'(mem_req), 0);
    tick();
    chk("s2_pf2_addr", 32'(mem_addr), 2);
    chk("s2_pf2_req", 32'(mem_req), 1);
    wait_quiet();
    chk("s2_addr1_once", 32'(ack_cnt[1]), 1);

    // Miss on PC=5 keeps the addr-2 buffer.
    exp_q.push_back('{16'hA5A5, 1'b0});
    pulse_start(13'd5);
    chk("s3_mem_addr", 32'(mem_addr), 5);
    chk("s3_ir_valid", 32'(ir_valid), 0);
    wait_ir();
    wait_quiet();
    exp_q.push_back('{16'h7F12, 1'b1});
    pulse_start(13'd2);
    chk("s3_pf_hit2", 32'(pf_hit), 1);
    chk("s3_addr2_once", 32'(ack_cnt[2]), 1);
    wait_quiet();

    // Start PC=2 while its prefetch is in flight.
    do_reset();
    exp_q.push_back('{16'h2A85, 1'b0});
    pulse_start(13'd0);
    wait_ir();
    wait_quiet();
    mem_wait = 4;
    exp_q.push_back('{16'h4C3B, 1'b1});
    pulse_start(13'd1);
    tick();
    chk("s4_pf_addr", 32'(mem_addr), 2);
    c2 = ack_cnt[2];
    exp_q.push_back('{16'h7F12, 1'b1});
    pulse_start(13'd2);
    chk("s4_ir_cleared", 32'(ir_valid), 0);
    chk("s4_busy", 32'(fetch_busy), 1);
    wait_ir();
    chk("s4_pf_hit", 32'(pf_hit), 1);
    tick();
    chk("s4_next_pf", 32'(mem_addr), 3);
    wait_quiet();
    chk("s4_one_txn", 32'(ack_cnt[2]), 32'(c2 + 1));

    // Start PC=6 during prefetch of addr 2: back-to-back relaunch.
    do_reset();
    exp_q.push_back('{16'h2A85, 1'b0});
    pulse_start(13'd0);
    wait_ir();
    wait_quiet();
    exp_q.push_back('{16'h4C3B, 1'b1});
    pulse_start(13'd1);
    tick();
    exp_q.push_back('{16'h1357, 1'b0});
    pulse_start(13'd6);
    gap = 0;
    n = 0;
    while (mem_addr != 13'd6 && n < 20) begin
      if (!mem_req) gap = 1;
      tick();
      n++;
    end
    chk("s5_mem_addr", 32'(mem_addr), 6);
    chk("s5_req_high", 32'(mem_req), 1);
    chk("s5_no_gap", 32'(gap), 0);
    chk("s5_ir_valid", 32'(ir_valid), 0);
    wait_ir();
    wait_quiet();

    // Wrap at 8191, then reset mid-fetch.
    do_reset();
    mem_wait = 2;
    exp_q.push_back('{mem_word(13'd8191), 1'b0});
    pulse_start(13'd8191);
    wait_ir();
    tick();
    chk("s6_wrap_req", 32'(mem_req), 1);
    chk("s6_wrap_addr", 32'(mem_addr), 0);
    wait_quiet();
    pulse_start(13'd4);
    chk("s6_fetch_addr", 32'(mem_addr), 4);
    chk("s6_fetch_req", 32'(mem_req), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_req", 32'(mem_req), 0);
    chk("s6_async_irv", 32'(ir_valid), 0);
    chk("s6_async_op", 32'(Opcode), 0);
    chk("s6_async_imm", 32'(imm), 0);
    chk("s6_async_addr", 32'(mem_addr), 0);
    tick();
    reset = 1'b0;
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    chk("s6_stray_irv", 32'(ir_valid), 0);
    chk("s6_stray_op", 32'(Opcode), 0);
    chk("s6_stray_req", 32'(mem_req), 0);
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
